// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline register with skid entry and synchronous flush
// The skid entry lets in_ready be a pure function of registered state while sustaining full rate.
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_main_q;
    logic [WIDTH-1:0] r_skid_q;
    logic             r_main_v;
    logic             r_skid_v;

    logic w_acc;
    logic w_pop;

    assign w_acc = in_valid & ~r_skid_v;
    assign w_pop = r_main_v & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_q <= RESET_VAL;
            r_skid_q <= RESET_VAL;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_q <= RESET_VAL;
            r_skid_q <= RESET_VAL;
        end else begin
            case ({r_main_v, r_skid_v})
                2'b00: begin
                    if (w_acc) begin
                        r_main_v <= 1'b1;
                        r_main_q <= in_data;
                    end
                end
                2'b10: begin
                    if (w_acc && w_pop) begin
                        r_main_q <= in_data;
                    end else if (w_acc) begin
                        r_skid_v <= 1'b1;
                        r_skid_q <= in_data;
                    end else if (w_pop) begin
                        r_main_v <= 1'b0;
                    end
                end
                2'b11: begin
                    // Skid always holds the younger word, so it is promoted on pop.
                    if (w_pop) begin
                        r_main_q <= r_skid_q;
                        r_skid_v <= 1'b0;
                    end
                end
                default: begin
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ~r_skid_v;
    assign out_valid = r_main_v;
    assign out_data  = r_main_q;
    assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard testbench for pipe_skid_reg
module tb_pipe_skid_reg;

    localparam int          W    = 16;
    localparam logic [W-1:0] RV  = 16'hC0DE;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    // Monitor: samples mid-cycle, before the edge that performs the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
            end else begin
                chk("occ_vs_model", {30'd0, occupancy}, exp_q.size());
                chk("in_ready_inv", {31'd0, in_ready}, {31'd0, (occupancy < 2'd2)});
                chk("out_valid_inv", {31'd0, out_valid}, {31'd0, (exp_q.size() > 0)});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_unexpected", {16'd0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("pop_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
                    end
                    out_log.push_back(out_data);
                end
                if (flush) begin
                    exp_q.delete();
                end else if (in_valid && in_ready) begin
                    exp_q.push_back(in_data);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] abc[3];
        abc[0] = 16'h000A;
        abc[1] = 16'h000B;
        abc[2] = 16'h000C;

        // Reset held with live input
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", {16'd0, out_data}, {16'd0, RV});
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        step();
        reset   = 1'b1;
        in_data = 16'h0101;
        step();
        chk("first_acc_valid", {31'd0, out_valid}, 32'd1);
        chk("first_acc_data", {16'd0, out_data}, 32'h0101);
        chk("first_acc_occ", {30'd0, occupancy}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("empty_after_pop", {30'd0, occupancy}, 32'd0);
        chk("hold_last_data", {16'd0, out_data}, 32'h0101);
        drain();

        // Full-rate streaming
        out_log.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
            chk("stream_data", {16'd0, out_data}, i);
        end
        drain();
        chk("stream_count", out_log.size(), 32'd8);
        for (int i = 0; i < out_log.size() && i < 8; i++)
            chk("stream_order", {16'd0, out_log[i]}, i + 1);

        // Backpressure into skid
        out_log.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        step();
        in_data   = 16'h000B;
        step();
        chk("bp_occ2", {30'd0, occupancy}, 32'd2);
        chk("bp_in_ready0", {31'd0, in_ready}, 32'd0);
        in_data   = 16'h000C;
        step();
        chk("bp_hold_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_hold_data", {16'd0, out_data}, 32'h000A);
        out_ready = 1'b1;
        step();
        chk("bp_promote", {16'd0, out_data}, 32'h000B);
        chk("bp_in_ready1", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        step();
        drain();
        chk("bp_count", out_log.size(), 32'd3);
        for (int i = 0; i < out_log.size() && i < 3; i++)
            chk("bp_order", {16'd0, out_log[i]}, {16'd0, abc[i]});

        // Flush from TWO with incoming word
        out_log.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0011;
        step();
        in_data   = 16'h0022;
        step();
        chk("fl_occ2", {30'd0, occupancy}, 32'd2);
        flush   = 1'b1;
        in_data = 16'h0033;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_out_data", {16'd0, out_data}, {16'd0, RV});
        drain();
        chk("fl_nothing_out", out_log.size(), 32'd0);

        // Async reset while in TWO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0055;
        step();
        in_data   = 16'h0066;
        step();
        chk("ar_occ2", {30'd0, occupancy}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_occ", {30'd0, occupancy}, 32'd0);
        chk("ar_out_data", {16'd0, out_data}, {16'd0, RV});
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        drain();

        // Random traffic with occasional flush
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        drain();
        chk("final_empty", {30'd0, occupancy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
